// File: rtl/alu_pkg.sv
// Shared opcode and FSM state encodings for alu_muldiv and its iteration core.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_MULT  = 4'b1000;
  localparam logic [3:0] ALU_MULTU = 4'b1001;
  localparam logic [3:0] ALU_DIV   = 4'b1010;
  localparam logic [3:0] ALU_DIVU  = 4'b1011;
  localparam logic [3:0] ALU_MFHI  = 4'b1100;
  localparam logic [3:0] ALU_MFLO  = 4'b1101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/alu_iter_core.sv
// Unsigned shift-add multiplier / restoring divider, one bit per cycle for WIDTH cycles.
// Multiply leaves the product in {hi_o,lo_o}; divide leaves remainder in hi_o, quotient in lo_o.
module alu_iter_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             last_o
);

  logic [WIDTH-1:0] acc_q, sh_q, m_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, div_q;

  logic [WIDTH:0]   msum, rshift, rdiff;
  logic [WIDTH-1:0] acc_d, sh_d;

  always_comb begin
    msum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
    rshift = {acc_q, sh_q[WIDTH-1]};
    rdiff  = rshift - {1'b0, m_q};
    if (!div_q) begin
      acc_d = msum[WIDTH:1];
      sh_d  = {msum[0], sh_q[WIDTH-1:1]};
    end else if (!rdiff[WIDTH]) begin
      // No borrow: the shifted remainder covers the divisor, so keep the difference.
      acc_d = rdiff[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = rshift[WIDTH-1:0];
      sh_d  = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      sh_q   <= '0;
      m_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      div_q  <= 1'b0;
    end else if (start_i) begin
      acc_q  <= '0;
      sh_q   <= a_i;
      m_q    <= b_i;
      cnt_q  <= CNT_W'(WIDTH - 1);
      busy_q <= 1'b1;
      div_q  <= is_div_i;
    end else if (busy_q) begin
      acc_q <= acc_d;
      sh_q  <= sh_d;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  assign hi_o   = acc_q;
  assign lo_o   = sh_q;
  assign last_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/alu_muldiv.sv
// Registered EX-stage ALU with iterative MULT/DIV and HI/LO registers.
// Optional macro ALU_OVF_TRAP_EN enables the signed ADD/SUB overflow flag on ovf.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             ovf,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] result_q, hi_q, lo_q, a_q;
  logic             out_valid_q, zero_q, dbz_q;
  logic             md_div_q, bz_q, negp_q, nega_q;

  logic             accept, is_md, accept_md, accept_simple;
  logic             sa, sb;
  logic [WIDTH-1:0] a_mag, b_mag, sum, diff, simple_res;
  logic [WIDTH-1:0] core_hi, core_lo, hi_fix, lo_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic             core_last;

  assign in_ready      = (state_q == S_IDLE);
  assign accept        = in_valid && in_ready;
  assign is_md         = (alu_ctrl[3:2] == 2'b10);
  assign accept_md     = accept && is_md;
  assign accept_simple = accept && !is_md;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    simple_res = '0;
    case (alu_ctrl)
      ALU_AND:  simple_res = a & b;
      ALU_OR:   simple_res = a | b;
      ALU_ADD:  simple_res = sum;
      ALU_XOR:  simple_res = a ^ b;
      ALU_NOR:  simple_res = ~(a | b);
      ALU_SLT:  simple_res[0] = ($signed(a) < $signed(b));
      ALU_SUB:  simple_res = diff;
      ALU_SLTU: simple_res[0] = (a < b);
      ALU_MFHI: simple_res = hi_q;
      ALU_MFLO: simple_res = lo_q;
      default:  simple_res = '0;
    endcase
  end

  // Signed variants (even opcode LSB) iterate on magnitudes; signs are reapplied in FIX.
  assign sa    = !alu_ctrl[0] && a[WIDTH-1];
  assign sb    = !alu_ctrl[0] && b[WIDTH-1];
  assign a_mag = sa ? -a : a;
  assign b_mag = sb ? -b : b;

  alu_iter_core #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (accept_md),
    .is_div_i(alu_ctrl[1]),
    .a_i     (a_mag),
    .b_i     (b_mag),
    .hi_o    (core_hi),
    .lo_o    (core_lo),
    .last_o  (core_last)
  );

  assign prod_fix = negp_q ? -{core_hi, core_lo} : {core_hi, core_lo};

  always_comb begin
    {hi_fix, lo_fix} = prod_fix;
    if (md_div_q) begin
      if (bz_q) begin
        hi_fix = a_q;
        lo_fix = '1;
      end else begin
        lo_fix = negp_q ? -core_lo : core_lo;
        hi_fix = nega_q ? -core_hi : core_hi;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept_md) state_d = S_ITER;
      S_ITER:  if (core_last) state_d = S_FIX;
      S_FIX:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      dbz_q       <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      a_q         <= '0;
      md_div_q    <= 1'b0;
      bz_q        <= 1'b0;
      negp_q      <= 1'b0;
      nega_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= accept_simple || (state_q == S_FIX);
      if (accept_simple) begin
        result_q <= simple_res;
        zero_q   <= (simple_res == '0);
        dbz_q    <= 1'b0;
      end else if (state_q == S_FIX) begin
        result_q <= lo_fix;
        zero_q   <= (lo_fix == '0);
        dbz_q    <= md_div_q && bz_q;
        hi_q     <= hi_fix;
        lo_q     <= lo_fix;
      end
      if (accept_md) begin
        a_q      <= a;
        md_div_q <= alu_ctrl[1];
        bz_q     <= (b == '0);
        negp_q   <= sa ^ sb;
        nega_q   <= sa;
      end
    end
  end

`ifdef ALU_OVF_TRAP_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = 1'b0;
    if (alu_ctrl == ALU_ADD)
      ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (alu_ctrl == ALU_SUB)
      ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ovf_q <= 1'b0;
    else if (accept_simple)     ovf_q <= ovf_d;
    else if (state_q == S_FIX)  ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign out_valid   = out_valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: issued ops push model expectations, a monitor pops on out_valid.
module tb_alu_muldiv;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   alu_ctrl = 4'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, div_by_zero, ovf;
  logic [W-1:0] result, hi, lo;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_ctrl   (alu_ctrl),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .result     (result),
    .zero       (zero),
    .div_by_zero(div_by_zero),
    .ovf        (ovf),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        dbz;
    logic        ov;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        me;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int          n_cmp = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the opcode definitions, using wide arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                       output exp_t e);
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sq, sr;
    e.res = '0; e.dbz = 1'b0; e.ov = 1'b0; e.cyc = 0;
    case (op)
      4'd0:  e.res = x & y;
      4'd1:  e.res = x | y;
      4'd2:  e.res = x + y;
      4'd3:  e.res = x ^ y;
      4'd4:  e.res = ~(x | y);
      4'd5:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:  e.res = x - y;
      4'd7:  e.res = (x < y) ? 32'd1 : 32'd0;
      4'd8: begin
        sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
        {m_hi, m_lo} = sp;
      end
      4'd9: begin
        up = {32'd0, x} * {32'd0, y};
        {m_hi, m_lo} = up;
      end
      4'd10: begin
        if (y == 0) begin
          m_hi = x; m_lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          m_hi = 0; m_lo = x;
        end else begin
          sq = $signed(x) / $signed(y);
          sr = $signed(x) % $signed(y);
          m_lo = sq; m_hi = sr;
        end
      end
      4'd11: begin
        if (y == 0) begin
          m_hi = x; m_lo = 32'hFFFF_FFFF; e.dbz = 1'b1;
        end else begin
          m_lo = x / y; m_hi = x % y;
        end
      end
      4'd12: e.res = m_hi;
      4'd13: e.res = m_lo;
      default: e.res = '0;
    endcase
    if (op >= 4'd8 && op <= 4'd11) e.res = m_lo;
`ifdef ALU_OVF_TRAP_EN
    if (op == 4'd2) e.ov = (x[31] == y[31]) && (e.res[31] != x[31]);
    if (op == 4'd6) e.ov = (x[31] != y[31]) && (e.res[31] != x[31]);
`endif
    e.z  = (e.res == 0);
    e.hi = m_hi;
    e.lo = m_lo;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    int   g = 0;
    while (!in_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("in_ready_at_issue", {63'd0, in_ready}, 64'd1);
    alu_ctrl = op; a = x; b = y; in_valid = 1'b1;
    model(op, x, y, e);
    e.cyc = cyc + ((op >= 4'd8 && op <= 4'd11) ? 34 : 1);
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called right after issuing a mul/div: busy for cycles 1..34, garbage requests ignored.
  task automatic wait_md(input bit garbage);
    for (int k = 1; k <= 34; k++) begin
      chk("busy_in_ready", {63'd0, in_ready}, 64'd0);
      if (garbage && k >= 2 && k <= 8) begin
        in_valid = 1'b1; alu_ctrl = 4'($urandom); a = $urandom; b = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("ready_after_md", {63'd0, in_ready}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        me = q.pop_front();
        chk("result",      {32'd0, result}, {32'd0, me.res});
        chk("zero",        {63'd0, zero}, {63'd0, me.z});
        chk("div_by_zero", {63'd0, div_by_zero}, {63'd0, me.dbz});
        chk("ovf",         {63'd0, ovf}, {63'd0, me.ov});
        chk("hi",          {32'd0, hi}, {32'd0, me.hi});
        chk("lo",          {32'd0, lo}, {32'd0, me.lo});
        chk("latency",     64'(cyc), 64'(me.cyc));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] x, y;
    int          g;

    repeat (3) @(negedge clk);
    chk("rst_result",    {32'd0, result}, 64'd0);
    chk("rst_hi",        {32'd0, hi}, 64'd0);
    chk("rst_lo",        {32'd0, lo}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_flags",     {61'd0, zero, div_by_zero, ovf}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {63'd0, in_ready}, 64'd1);

    issue(4'd2, 32'd7, 32'd5);
    issue(4'd6, 32'd5, 32'd5);
    issue(4'd5, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1);
    issue(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(4'd1, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(4'd3, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00);
    issue(4'd8, 32'hFFFF_FFFD, 32'd7);          wait_md(1'b0);
    issue(4'd9, 32'hFFFF_FFFF, 32'd2);          wait_md(1'b1);
    issue(4'd10, 32'hFFFF_FFF9, 32'd2);         wait_md(1'b1);
    issue(4'd11, 32'd9, 32'd0);                 wait_md(1'b0);
    issue(4'd12, 32'd0, 32'd0);
    issue(4'd13, 32'd0, 32'd0);
    issue(4'd10, 32'h8000_0000, 32'hFFFF_FFFF); wait_md(1'b1);
    issue(4'd12, 32'd0, 32'd0);
    issue(4'd13, 32'd0, 32'd0);
    issue(4'd2, 32'h7FFF_FFFF, 32'd1);
    issue(4'd6, 32'h8000_0000, 32'd1);
    issue(4'd14, 32'd3, 32'd4);
    issue(4'd15, 32'd3, 32'd4);
    repeat (3) @(negedge clk);

    // Abort a MULT at cycle 10: HI/LO clear and no result may appear.
    issue(4'd8, 32'h1234_5678, 32'h0BAD_F00D);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    q.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("abort_hi", {32'd0, hi}, 64'd0);
    chk("abort_lo", {32'd0, lo}, 64'd0);
    chk("abort_out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_ready", {63'd0, in_ready}, 64'd1);
    repeat (40) @(negedge clk);
    issue(4'd12, 32'd0, 32'd0);
    issue(4'd13, 32'd0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = $urandom;
      y  = $urandom;
      case ($urandom_range(0, 9))
        0: y = 32'd0;
        1: begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        2: y = 32'($urandom_range(1, 9));
        3: begin x = 32'h7FFF_FFFF; y = 32'($urandom_range(0, 3)); end
        default: ;
      endcase
      issue(op, x, y);
    end

    g = 0;
    while (q.size() != 0 && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Parametrised successor to the MIPS single-cycle ALU.
- Registered ALU with a valid/ready handshake.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, signed/unsigned variants and MFHI/MFLO.
- Sits in the EX stage; the pipeline stalls while in_ready is low.

Parameters:
- WIDTH, 32, operand/result width (>=4).
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high when idle; a request is accepted when in_valid && in_ready.
- alu_ctrl  in  4  opcode.
- a  in  WIDTH  operand A (rs).
- b  in  WIDTH  operand B (rt).
- out_valid  out  1  single-cycle result pulse.
- result  out  WIDTH  result; holds its value between pulses.
- zero  out  1  (result == 0), registered with result.
- div_by_zero  out  1  valid with out_valid; set for DIV/DIVU with b == 0.
- ovf  out  1  signed overflow flag (see Optional Feature).
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Opcodes (legacy 3-bit codes are preserved with MSB = 0):
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR.
  - 0101 SLT (signed), 0110 SUB, 0111 SLTU (legacy unsigned compare).
  - 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1100 MFHI, 1101 MFLO.
  - 1110 and 1111 produce result 0 with a normal 1-cycle latency.
- Reset: every output register is 0, state = IDLE, and in_ready is 1 one cycle after rst_n deasserts.
  - Reset asserted mid-iteration aborts the operation; HI/LO clear to 0 and no out_valid is produced.
- States:
  - IDLE -> (accept simple/MF op) -> IDLE, with out_valid in the following cycle.
  - IDLE -> (accept mul/div) -> ITER.
  - ITER: stays for exactly WIDTH cycles (counter WIDTH-1 down to 0), then -> FIX.
  - FIX: one cycle applying sign correction and writing HI/LO, then -> DONE.
  - DONE: pulses out_valid, then -> IDLE.
  - in_ready = (state == IDLE).
- Latency, counting the accept edge as cycle 0:
  - Simple and MF ops: out_valid at cycle 1.
  - Mul/div: out_valid at cycle WIDTH+2.
  - Back-to-back simple ops sustain 1 op per cycle.
- Arithmetic:
  - ADD and SUB wrap modulo 2^WIDTH.
  - Signed ops use absolute-value operands inside ITER; the sign is fixed in FIX.
  - MULT/MULTU: {HI,LO} = full 2*WIDTH product via shift-add.
  - DIV/DIVU: restoring division; LO = quotient (truncated toward zero), HI = remainder (takes the sign of the dividend).
  - For mul/div, result = LO and zero = (LO == 0).
- Boundary cases:
  - Divide by zero: LO = all ones, HI = a, div_by_zero = 1.
  - DIV with a = MIN and b = -1: LO = MIN, HI = 0, no flag.
  - Simple ops leave HI/LO unchanged.
  - MFHI/MFLO return the current HI/LO.
  - in_valid while busy is ignored; operands are captured at accept, so later changes to a/b have no effect.

Optional Feature:
- Macro: ALU_OVF_TRAP_EN.
- Defined: ovf is registered with result and is 1 when signed ADD/SUB overflows, i.e. operands of like sign (ADD) or unlike sign (SUB) give a result sign that differs from a.
- Not defined: ovf is tied 0 and no overflow logic is synthesised.
- Results are identical either way.

Decomposition:
- Shared package alu_pkg contains:
  - Opcode localparams (ALU_AND ... ALU_MFLO).
  - State encoding (S_IDLE, S_ITER, S_FIX, S_DONE).
- Sub-module alu_iter_core:
  - Shift-add/restoring datapath holding the accumulator, the operand shifter and the counter.
  - Driven by a start/mode input from the top-level FSM.
  - Returns raw unsigned {hi,lo}.

Test Plan (WIDTH = 32):
- Reset, then ADD a=7 b=5 -> out_valid at cycle 1, result=12, zero=0, in_ready stays 1. SUB 5-5 -> result=0, zero=1.
- SLT a=0xFFFFFFFF b=1 -> result=1. SLTU with the same operands -> result=0. AND/OR/XOR/NOR of 0xF0F0F0F0 and 0xFF00FF00 return 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0 and 0x000F000F.
- MULT a=-3 b=7 -> out_valid exactly at cycle 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULTU 0xFFFFFFFF*2 -> HI=1, LO=0xFFFFFFFE. in_ready=0 for cycles 1-34.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 9/0 -> LO=0xFFFFFFFF, HI=9, div_by_zero=1. DIV 0x80000000/-1 -> LO=0x80000000, HI=0. MFHI/MFLO then return those values.
- Assert rst_n at cycle 10 of a MULT -> no out_valid, HI=LO=0, in_ready=1 after release. in_valid pulsed during ITER -> ignored.
- With ALU_OVF_TRAP_EN: ADD 0x7FFFFFFF+1 -> result=0x80000000, ovf=1. Without the macro -> ovf=0 and the same result.
